op_feed: RTL and testbench

OP_FEED -- requirements
Module: op_feed

---
 rtl/op_feed.sv | 134 +++++++++++++
 tb/tb_op_feed.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_feed.sv
// Operand FIFO feeding a registered op stage; a/b/mode update only on pop.
// Optional sticky underrun flag and saturating counter under OP_FEED_UNDERRUN_EN.
module op_feed #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    input  logic                     in_mode,
    input  logic                     issue_en,
    output logic [W-1:0]             a,
    output logic [W-1:0]             b,
    output logic                     mode,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * W + 1;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  count_nxt;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [EW-1:0]  mem [DEPTH];
    logic           push;
    logic           pop;

    assign in_ready = (state != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = issue_en && (state != EMPTY);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    count_nxt = CW'(1);
                    state_nxt = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop) begin
                    count_nxt = count + CW'(1);
                    state_nxt = (count_nxt == CW'(DEPTH)) ? FULL : PARTIAL;
                end else if (pop && !push) begin
                    count_nxt = count - CW'(1);
                    state_nxt = (count_nxt == '0) ? EMPTY : PARTIAL;
                end
            end
            FULL: begin
                // push is blocked while full, so only a pop can move us
                if (pop) begin
                    count_nxt = count - CW'(1);
                    state_nxt = PARTIAL;
                end
            end
            default: begin
                state_nxt = EMPTY;
                count_nxt = '0;
            end
        endcase
    end

    // Storage carries no reset; stale entries are unreachable after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {in_mode, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            count     <= '0;
            wptr      <= '0;
            rptr      <= '0;
            a         <= '0;
            b         <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            out_valid <= pop;
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr              <= rptr + AW'(1);
                {mode, a, b}      <= mem[rptr];
            end
        end
    end

`ifdef OP_FEED_UNDERRUN_EN
    logic       und_flag;
    logic [7:0] und_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            und_flag <= 1'b0;
            und_cnt  <= '0;
        end else if (issue_en && (state == EMPTY)) begin
            und_flag <= 1'b1;
            if (und_cnt != 8'hff) begin
                und_cnt <= und_cnt + 8'd1;
            end
        end
    end

    assign underrun     = und_flag;
    assign underrun_cnt = und_cnt;
`else
    assign underrun     = 1'b0;
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_op_feed.sv
// Bench for op_feed: directed vector table, hand sequences for wrap and
// async reset, underrun soak, and random traffic against a queue model.
module tb_op_feed;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_mode;
    logic          issue_en;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          mode;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          underrun;
    logic [7:0]    underrun_cnt;

    op_feed #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_mode      (in_mode),
        .issue_en     (issue_en),
        .a            (a),
        .b            (b),
        .mode         (mode),
        .out_valid    (out_valid),
        .count        (count),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
    } ent_t;

    ent_t         q[$];
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic         mm;
    logic         mov;
    logic         mund;
    int           mcnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ma   = '0;
        mb   = '0;
        mm   = 1'b0;
        mov  = 1'b0;
        mund = 1'b0;
        mcnt = 0;
    endtask

    task automatic step(input logic v, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic xm,
                        input logic ie);
        logic do_push;
        logic do_pop;
        ent_t e;
        @(negedge clk);
        in_valid = v;
        in_a     = xa;
        in_b     = xb;
        in_mode  = xm;
        issue_en = ie;
        #1;
        chk("in_ready", in_ready, (q.size() < DEPTH));
        do_push = v && (q.size() < DEPTH);
        do_pop  = ie && (q.size() != 0);
`ifdef OP_FEED_UNDERRUN_EN
        if (ie && q.size() == 0) begin
            mund = 1'b1;
            if (mcnt < 255) mcnt++;
        end
`endif
        @(posedge clk);
        #1;
        mov = do_pop;
        if (do_pop) begin
            e  = q.pop_front();
            ma = e.a;
            mb = e.b;
            mm = e.m;
        end
        if (do_push) begin
            e.a = xa;
            e.b = xb;
            e.m = xm;
            q.push_back(e);
        end
        chk("a", a, ma);
        chk("b", b, mb);
        chk("mode", mode, mm);
        chk("out_valid", out_valid, mov);
        chk("count", count, q.size());
        chk("underrun", underrun, mund);
        chk("underrun_cnt", underrun_cnt, mcnt);
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         xm;
        logic         ie;
        int           ecnt;
        logic         eov;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         em;
        logic         erdy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 1,  2,  1, 0, 1, 0, 0,  0,  0, 1};
        tbl[1]  = '{0, 0,  0,  0, 1, 0, 1, 1,  2,  1, 1};
        tbl[2]  = '{1, 10, 20, 0, 0, 1, 0, 1,  2,  1, 1};
        tbl[3]  = '{1, 11, 21, 1, 0, 2, 0, 1,  2,  1, 1};
        tbl[4]  = '{1, 12, 22, 0, 0, 3, 0, 1,  2,  1, 1};
        tbl[5]  = '{1, 13, 23, 1, 0, 4, 0, 1,  2,  1, 0};
        tbl[6]  = '{1, 14, 24, 0, 0, 4, 0, 1,  2,  1, 0};
        tbl[7]  = '{1, 15, 25, 1, 1, 3, 1, 10, 20, 0, 1};
        tbl[8]  = '{0, 0,  0,  0, 1, 2, 1, 11, 21, 1, 1};
        tbl[9]  = '{0, 0,  0,  0, 0, 2, 0, 11, 21, 1, 1};
        tbl[10] = '{1, 16, 26, 0, 1, 2, 1, 12, 22, 0, 1};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_mode  = 1'b0;
        issue_en = 1'b0;
        model_reset();
        #12;
        chk("rst a", a, 0);
        chk("rst count", count, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst underrun", underrun, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].xa, tbl[i].xb, tbl[i].xm, tbl[i].ie);
            chk($sformatf("tbl%0d count", i), count, tbl[i].ecnt);
            chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].eov);
            chk($sformatf("tbl%0d a", i), a, tbl[i].ea);
            chk($sformatf("tbl%0d b", i), b, tbl[i].eb);
            chk($sformatf("tbl%0d mode", i), mode, tbl[i].em);
            chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].erdy);
        end

        // steady push+pop at count=2 across pointer wrap
        for (int i = 0; i < 6; i++) begin
            step(1, 100 + i, 200 + i, i[0], 1);
        end
        chk("wrap count", count, 2);
        chk("wrap last a", a, 103);

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("drain a", a, 105);
        step(1, 300, 400, 1, 0);
        step(1, 301, 401, 0, 0);
        step(1, 302, 402, 1, 0);
        chk("pre-rst count", count, 3);

        @(negedge clk);
        issue_en = 1'b0;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async rst a", a, 0);
        chk("async rst b", b, 0);
        chk("async rst mode", mode, 0);
        chk("async rst count", count, 0);
        chk("async rst out_valid", out_valid, 0);
        chk("async rst in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        step(1, 500, 600, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("post-rst first a", a, 500);
        chk("post-rst first b", b, 600);

        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 0, 1);
        end
`ifdef OP_FEED_UNDERRUN_EN
        chk("underrun soak flag", underrun, 1);
        chk("underrun soak cnt", underrun_cnt, 255);
`else
        chk("underrun soak flag", underrun, 0);
        chk("underrun soak cnt", underrun_cnt, 0);
`endif

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 55, $urandom, $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 99) < 50);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
